// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and constants for the serial add/sub datapath
package serial_arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int cnt_w(input int word_w);
    return $clog2(word_w);
  endfunction

endpackage

// File: rtl/serial_fa_lane.sv
// rtl/serial_fa_lane.sv - one bit-serial full-adder lane with its own carry and word-end flags
module serial_fa_lane
  import serial_arith_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic y,
  input  logic mode,
  input  logic first,
  input  logic en,
  input  logic last,
  input  logic clr_i,
  output logic sum,
  output logic carry_out,
  output logic ovf
);

  logic carry_q, carry_d;
  logic sum_q, sum_d;
  logic cout_q, cout_d;
  logic ovf_q, ovf_d;
  logic c_in, yy, c_nxt;

  always_comb begin
    // Bit 0 takes its carry-in from the mode so subtraction gets the +1 of ~y + 1.
    c_in    = first ? mode : carry_q;
    yy      = y ^ mode;
    c_nxt   = (x & yy) | (c_in & (x ^ yy));
    carry_d = carry_q;
    sum_d   = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (en) begin
      carry_d = c_nxt;
      sum_d   = x ^ yy ^ c_in;
    end
    if (first) begin
      cout_d = 1'b0;
      ovf_d  = 1'b0;
    end
    if (en && last) begin
      cout_d = c_nxt;
      ovf_d  = c_in ^ c_nxt;
    end
    if (clr_i) begin
      carry_d = 1'b0;
      sum_d   = 1'b0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      sum_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - multi-lane framed bit-serial adder/subtractor: word FSM, bit counter, lanes
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int LANES  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             start,
  input  logic             sub,
  input  logic [LANES-1:0] x,
  input  logic [LANES-1:0] y,
  output logic [LANES-1:0] sum,
  output logic             sum_vld,
  output logic             sum_last,
  output logic             busy,
  output logic [LANES-1:0] carry_out,
  output logic [LANES-1:0] ovf
);

  localparam int CW = cnt_w(WORD_W);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;
  logic          accept, en, msb, mode_eff;

  always_comb begin
    accept   = (state_q == IDLE) && start && !clr;
    msb      = (state_q == RUN) && (cnt_q == CW'(WORD_W - 1));
    en       = accept || ((state_q == RUN) && !clr);
    mode_eff = accept ? (sub ? MODE_SUB : MODE_ADD) : mode_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    vld_d    = 1'b0;
    last_d   = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      mode_d  = MODE_ADD;
    end else if (accept) begin
      state_d = RUN;
      cnt_d   = CW'(1);
      mode_d  = mode_eff;
      vld_d   = 1'b1;
    end else if (state_q == RUN) begin
      vld_d   = 1'b1;
      last_d  = msb;
      cnt_d   = msb ? '0 : cnt_q + CW'(1);
      state_d = msb ? IDLE : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_ADD;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign sum_vld  = vld_q;
  assign sum_last = last_q;
  assign busy     = (state_q == RUN);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    serial_fa_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .x         (x[i]),
      .y         (y[i]),
      .mode      (mode_eff),
      .first     (accept),
      .en        (en),
      .last      (msb),
      .clr_i     (clr),
      .sum       (sum[i]),
      .carry_out (carry_out[i]),
      .ovf       (ovf[i])
    );
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed self-checking bench for serial_addsub
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst, clr, start, sub;
  logic [1:0] x, y, sum, carry_out, ovf;
  logic       sum_vld, sum_last, busy;

  logic       s_clr, s_start, s_sub, s_x, s_y;
  logic       s_sum, s_vld, s_last, s_busy, s_cout, s_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] r0 [0:31];
  logic [7:0] r1 [0:31];
  logic [1:0] rc [0:31];
  logic [1:0] ro [0:31];
  logic [7:0] acc0, acc1;
  int nw = 0, vld_cnt = 0, run = 0, max_run = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WORD_W(8), .LANES(2)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .sub(sub), .x(x), .y(y),
    .sum(sum), .sum_vld(sum_vld), .sum_last(sum_last), .busy(busy),
    .carry_out(carry_out), .ovf(ovf)
  );

  serial_addsub #(.WORD_W(2), .LANES(1)) dut_w2 (
    .clk(clk), .rst(rst), .clr(s_clr), .start(s_start), .sub(s_sub), .x(s_x), .y(s_y),
    .sum(s_sum), .sum_vld(s_vld), .sum_last(s_last), .busy(s_busy),
    .carry_out(s_cout), .ovf(s_ovf)
  );

  // Collect serial results per word; a word is recorded only when its MSB is flagged.
  always @(negedge clk) begin
    if (sum_vld) begin
      acc0 = {sum[0], acc0[7:1]};
      acc1 = {sum[1], acc1[7:1]};
      vld_cnt++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (sum_last && nw < 32) begin
      r0[nw] = acc0;
      r1[nw] = acc1;
      rc[nw] = carry_out;
      ro[nw] = ovf;
      nw++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [7:0] a0, input logic [7:0] b0,
                            input logic [7:0] a1, input logic [7:0] b1,
                            input logic s, input int pulse_at, input int abort_at,
                            input logic abort_rst, input logic chk_first);
    for (int i = 0; i < 8; i++) begin
      x     = {a1[i], a0[i]};
      y     = {b1[i], b0[i]};
      start = (i == 0) || (i == pulse_at);
      sub   = (i == 0) ? s : 1'b1;
      if (i == abort_at) begin
        if (abort_rst) rst = 1'b1;
        else           clr = 1'b1;
      end
      if (i == 0 && chk_first) check("vld_before_first_edge", sum_vld, 1'b0);
      tick();
      start = 1'b0;
      if (i == abort_at) begin
        rst = 1'b0;
        clr = 1'b0;
        x   = '0;
        y   = '0;
        sub = 1'b0;
        return;
      end
      if (i == 0 && chk_first) begin
        check("vld_after_first_edge", sum_vld, 1'b1);
        check("cout_zero_in_flight", carry_out, 2'b00);
        check("ovf_zero_in_flight", ovf, 2'b00);
      end
      if (i == pulse_at) check("busy_at_ignored_start", busy, 1'b1);
    end
    x   = '0;
    y   = '0;
    sub = 1'b0;
  endtask

  initial begin
    int w, v0;
    rst = 1'b1; clr = 1'b0; start = 1'b0; sub = 1'b0; x = '0; y = '0;
    s_clr = 1'b0; s_start = 1'b0; s_sub = 1'b0; s_x = 1'b0; s_y = 1'b0;
    acc0 = '0; acc1 = '0;
    repeat (2) tick();
    check("rst_sum_vld", sum_vld, 1'b0);
    check("rst_sum_last", sum_last, 1'b0);
    check("rst_sum", sum, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_carry_out", carry_out, 2'b00);
    check("rst_ovf", ovf, 2'b00);
    rst = 1'b0;
    tick();

    // 1: add with signed overflow on both lanes
    w = nw; v0 = vld_cnt;
    drive_word(8'h5A, 8'h3C, 8'h7F, 8'h01, 1'b0, -1, -1, 1'b0, 1'b1);
    check("t1_last_on_8th", sum_last, 1'b1);
    tick();
    check("t1_vld_drops", sum_vld, 1'b0);
    check("t1_vld_count", vld_cnt - v0, 8);
    check("t1_words", nw - w, 1);
    check("t1_l0_sum", r0[w], 8'h96);
    check("t1_l1_sum", r1[w], 8'h80);
    check("t1_cout", rc[w], 2'b00);
    check("t1_ovf", ro[w], 2'b11);

    // 2: subtract, with and without borrow
    w = nw;
    drive_word(8'h10, 8'h20, 8'h20, 8'h10, 1'b1, -1, -1, 1'b0, 1'b1);
    tick();
    check("t2_l0_sum", r0[w], 8'hF0);
    check("t2_l1_sum", r1[w], 8'h10);
    check("t2_cout", rc[w], 2'b10);
    check("t2_ovf", ro[w], 2'b00);

    // 3: back-to-back words, add then sub
    w = nw; max_run = 0;
    drive_word(8'hFF, 8'h01, 8'h01, 8'h02, 1'b0, -1, -1, 1'b0, 1'b0);
    drive_word(8'h80, 8'h01, 8'h05, 8'h07, 1'b1, -1, -1, 1'b0, 1'b0);
    tick();
    check("t3a_l0_sum", r0[w], 8'h00);
    check("t3a_l1_sum", r1[w], 8'h03);
    check("t3a_cout", rc[w], 2'b01);
    check("t3a_ovf", ro[w], 2'b00);
    check("t3b_l0_sum", r0[w+1], 8'h7F);
    check("t3b_l1_sum", r1[w+1], 8'hFE);
    check("t3b_cout", rc[w+1], 2'b01);
    check("t3b_ovf", ro[w+1], 2'b01);
    check("t3_gapless_vld", max_run, 16);

    // 4: start with sub=1 mid-word must be ignored
    w = nw; v0 = vld_cnt;
    drive_word(8'h12, 8'h34, 8'hC0, 8'hC0, 1'b0, 3, -1, 1'b0, 1'b0);
    tick();
    check("t4_l0_sum", r0[w], 8'h46);
    check("t4_l1_sum", r1[w], 8'h80);
    check("t4_cout", rc[w], 2'b10);
    check("t4_ovf", ro[w], 2'b00);
    repeat (3) tick();
    check("t4_one_word", nw - w, 1);
    check("t4_vld_count", vld_cnt - v0, 8);
    check("t4_idle_after", busy, 1'b0);

    // 5: clr at bit 4, restart two cycles later
    w = nw; v0 = vld_cnt;
    drive_word(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, -1, 4, 1'b0, 1'b0);
    check("t5_clr_vld", sum_vld, 1'b0);
    check("t5_clr_busy", busy, 1'b0);
    check("t5_clr_sum", sum, 2'b00);
    tick();
    drive_word(8'h03, 8'h04, 8'h10, 8'h20, 1'b0, -1, -1, 1'b0, 1'b0);
    tick();
    check("t5_no_aborted_last", nw - w, 1);
    check("t5_l0_sum", r0[w], 8'h07);
    check("t5_l1_sum", r1[w], 8'h30);
    check("t5_cout", rc[w], 2'b00);
    check("t5_ovf", ro[w], 2'b00);
    check("t5_vld_count", vld_cnt - v0, 12);

    // 6a: rst mid-word
    drive_word(8'hF0, 8'hF0, 8'h0F, 8'h0F, 1'b1, -1, 5, 1'b1, 1'b0);
    check("t6_rst_vld", sum_vld, 1'b0);
    check("t6_rst_last", sum_last, 1'b0);
    check("t6_rst_sum", sum, 2'b00);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_cout", carry_out, 2'b00);
    check("t6_rst_ovf", ovf, 2'b00);
    tick();

    // 6b: WORD_W=2 edge case, 0b11 + 0b01
    s_start = 1'b1; s_x = 1'b1; s_y = 1'b1;
    tick();
    s_start = 1'b0;
    check("t6w2_bit0_vld", s_vld, 1'b1);
    check("t6w2_bit0_sum", s_sum, 1'b0);
    check("t6w2_bit0_last", s_last, 1'b0);
    s_x = 1'b1; s_y = 1'b0;
    tick();
    s_x = 1'b0;
    check("t6w2_bit1_sum", s_sum, 1'b0);
    check("t6w2_bit1_last", s_last, 1'b1);
    check("t6w2_cout", s_cout, 1'b1);
    check("t6w2_ovf", s_ovf, 1'b0);
    tick();
    check("t6w2_vld_end", s_vld, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
